bv_build_from_countid: RTL
==========================

Name: bv_build_from_countid

Overview:
- Inverse of the countid priority encoder: converts a stream of rule IDs (countids) back into a rule bit vector.
- Each frame is a burst of IDs delimited by first/last. Each ID is decoded one-hot and ORed into an accumulator, and the completed BV is presented on a registered output with valid/ready.
- Sits on the control/programming side of the BV pipeline. It builds per-field BV table entries from rule-ID lists before they are written into BV memory.

Parameters:
- WIDTH_BV, 64, width of produced bit vector; bit k corresponds to rule id k (LSB = id 0).
- WIDTH_COUNT, 6, width of rule id; requires WIDTH_BV <= 2**WIDTH_COUNT.

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  asynchronous reset, active-low (0 = reset)
- id_valid  in  1  input id beat present
- id  in  WIDTH_COUNT  rule id
- id_first  in  1  beat starts a new frame
- id_last  in  1  beat ends the frame
- id_ready  out  1  block accepts beat this cycle
- bv_out_valid  out  1  completed BV available
- bv_out  out  WIDTH_BV  completed BV
- bv_out_cnt  out  WIDTH_COUNT+1  ids accepted in frame, saturating
- bv_out_dup  out  1  frame contained an id already set
- bv_out_err  out  1  out-of-range id in frame, or frame aborted by early first
- bv_out_ready  in  1  downstream consumes output

Behaviour:
- Handshake and FSM:
  - Beat accepted when id_valid && id_ready.
  - id_ready = !bv_out_valid || bv_out_ready, combinational from output register state only.
  - id_ready never depends on id_valid.
  - FSM states: IDLE (no open frame) and ACCUM (frame open).
- Reset (reset = 0):
  - state = IDLE; accumulator = 0; cnt = 0; dup/err flags = 0.
  - bv_out_valid = 0, bv_out = 0, bv_out_cnt = 0, bv_out_dup = 0, bv_out_err = 0.
  - An in-flight frame is discarded with no output.
- Accepted beat with id_first = 1 (any state):
  - Accumulator = onehot(id); cnt = 1; dup = 0.
  - err = out-of-range(id), or 1 if the previous state was ACCUM (aborted frame).
  - Go to ACCUM.
- Accepted beat with id_first = 0 in ACCUM:
  - dup |= acc[id]; acc |= onehot(id); cnt = sat(cnt+1); err |= out-of-range(id).
- Accepted beat with id_first = 0 in IDLE: beat dropped, no state change.
- Out-of-range id (id >= WIDTH_BV): contributes no bit and sets err.
- Counter width: cnt saturates at 2**(WIDTH_COUNT+1)-1.
- Frame completion:
  - An accepted beat with id_last = 1 (after applying that beat's update, including first&&last single-beat frames) loads the output register: bv_out = final acc, plus cnt/dup/err.
  - bv_out_valid = 1 on the next cycle; latency is 1 cycle from the last beat to output valid.
  - State returns to IDLE and the accumulator clears to 0.
- Output hold: bv_out* are held stable while bv_out_valid && !bv_out_ready.
- Output pop:
  - bv_out_valid && bv_out_ready with no simultaneous load: bv_out_valid = 0 next cycle; data regs keep their value.
  - Simultaneous pop and load: new frame loaded, bv_out_valid stays 1. Back-to-back single-beat frames sustain 1 BV/cycle.
- Duplicate id: BV unchanged, dup set, cnt still increments.
- No combinational path from id_* to bv_out*.

Decomposition:
- Shared package `bv_pkg`:
  - WIDTH_BV and WIDTH_COUNT defaults.
  - FSM state encoding (IDLE = 1'b0, ACCUM = 1'b1).
  - Function `sat_inc`.
- Sub-module `countid_onehot_decode`: combinational id -> WIDTH_BV one-hot plus an out_of_range flag. It is reused by the BV memory writer.

Test Plan:
- Single-beat frame: first = last = 1, id = 5, bv_out_ready = 1 -> next cycle bv_out_valid = 1, bv_out = 64'h20, cnt = 1, dup = 0, err = 0.
- Multi-beat frame: ids 0, 63, 7 (first on 0, last on 7) -> bv_out = 64'h8000_0000_0000_0081, cnt = 3; duplicate id 7 added -> dup = 1, cnt = 4, same BV.
- Backpressure:
  - Frame completes while bv_out_ready = 0 -> id_ready = 0, and bv_out is stable for 5 held cycles.
  - Raise bv_out_ready -> pop, and id_ready = 1 in the same cycle.
  - 4 back-to-back single-beat frames, ids 1..4, with ready held high -> 4 consecutive output cycles: 2, 4, 8, 16.
- Abort and orphan beats:
  - first(id 2), then first(id 3) + last -> one output: bv = 64'h8, err = 1.
  - Beat with first = 0 in IDLE -> no output, no state change.
- Out-of-range id with WIDTH_BV = 48, WIDTH_COUNT = 6: frame ids 50, 1 -> bv = 48'h2, err = 1, cnt = 2.
- Reset mid-frame: assert reset = 0 after 2 of 3 beats -> all outputs are 0 immediately (async). After release, a new single-beat frame with id 9 -> bv = 64'h200 with no residue.

Source files
------------

// File: rtl/bv_pkg.sv
// Shared definitions for the rule-ID to bit-vector builder and its helpers.
package bv_pkg;

   localparam int WIDTH_BV_DEF    = 64;
   localparam int WIDTH_COUNT_DEF = 6;

   // Frame-tracking FSM encoding
   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] ACCUM = 1'b1;

   // Saturating increment: sticks at max_v instead of wrapping
   function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max_v);
      if (v >= max_v) return max_v;
      return v + 32'd1;
   endfunction

endpackage

// File: rtl/countid_onehot_decode.sv
// Combinational rule-id to one-hot decoder; ids at or beyond WIDTH_BV decode
// to all zeros and raise out_of_range.
module countid_onehot_decode
   import bv_pkg::*;
#(
   parameter int WIDTH_BV    = WIDTH_BV_DEF,
   parameter int WIDTH_COUNT = WIDTH_COUNT_DEF
) (
   input  logic [WIDTH_COUNT-1:0] id,
   output logic [WIDTH_BV-1:0]    onehot,
   output logic                   out_of_range
);

   // Compare the id against every bit position; unmatched ids yield no bit
   always_comb begin
      onehot       = '0;
      out_of_range = (32'(id) >= 32'(WIDTH_BV));
      for (int k = 0; k < WIDTH_BV; k++) begin
         onehot[k] = (32'(id) == 32'(k));
      end
   end

endmodule

// File: rtl/bv_build_from_countid.sv
// Rebuilds a rule bit vector from a framed stream of rule ids. Each accepted
// id is ORed into an accumulator; the frame's last beat loads a registered
// output stage with the BV, beat count, duplicate flag and error flag.
module bv_build_from_countid
   import bv_pkg::*;
#(
   parameter int WIDTH_BV    = WIDTH_BV_DEF,
   parameter int WIDTH_COUNT = WIDTH_COUNT_DEF
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   id_valid,
   input  logic [WIDTH_COUNT-1:0] id,
   input  logic                   id_first,
   input  logic                   id_last,
   output logic                   id_ready,
   output logic                   bv_out_valid,
   output logic [WIDTH_BV-1:0]    bv_out,
   output logic [WIDTH_COUNT:0]   bv_out_cnt,
   output logic                   bv_out_dup,
   output logic                   bv_out_err,
   input  logic                   bv_out_ready
);

   localparam int          CW      = WIDTH_COUNT + 1;
   localparam logic [31:0] CNT_MAX = (32'd1 << CW) - 32'd1;

   logic [0:0]          state_q;
   logic [WIDTH_BV-1:0] acc_p0;
   logic [CW-1:0]       cnt_p0;
   logic                dup_p0;
   logic                err_p0;

   logic [WIDTH_BV-1:0] onehot;
   logic                oor;
   logic                accept;
   logic                beat_upd;
   logic                load;
   logic [WIDTH_BV-1:0] acc_n;
   logic [CW-1:0]       cnt_n;
   logic                dup_n;
   logic                err_n;

   countid_onehot_decode #(
      .WIDTH_BV    (WIDTH_BV),
      .WIDTH_COUNT (WIDTH_COUNT)
   ) u_decode (
      .id           (id),
      .onehot       (onehot),
      .out_of_range (oor)
   );

   // Input may be taken whenever the output slot is empty or being drained
   assign id_ready = !bv_out_valid || bv_out_ready;
   assign accept   = id_valid && id_ready;

   // Frame update for the current beat; orphan beats in IDLE leave it untouched
   always_comb begin
      beat_upd = 1'b0;
      acc_n    = acc_p0;
      cnt_n    = cnt_p0;
      dup_n    = dup_p0;
      err_n    = err_p0;
      if (accept && id_first) begin
         beat_upd = 1'b1;
         acc_n    = onehot;
         cnt_n    = CW'(1);
         dup_n    = 1'b0;
         err_n    = oor || (state_q == ACCUM);
      end else if (accept && (state_q == ACCUM)) begin
         beat_upd = 1'b1;
         acc_n    = acc_p0 | onehot;
         cnt_n    = CW'(sat_inc(32'(cnt_p0), CNT_MAX));
         dup_n    = dup_p0 || |(acc_p0 & onehot);
         err_n    = err_p0 || oor;
      end
      load = beat_upd && id_last;
   end

   // Stage p0: frame state and accumulator
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         acc_p0  <= '0;
         cnt_p0  <= '0;
         dup_p0  <= 1'b0;
         err_p0  <= 1'b0;
      end else if (load) begin
         state_q <= IDLE;
         acc_p0  <= '0;
         cnt_p0  <= '0;
         dup_p0  <= 1'b0;
         err_p0  <= 1'b0;
      end else if (beat_upd) begin
         state_q <= ACCUM;
         acc_p0  <= acc_n;
         cnt_p0  <= cnt_n;
         dup_p0  <= dup_n;
         err_p0  <= err_n;
      end
   end

   // Stage p1: output register, loaded on frame end, cleared-valid on pop
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bv_out_valid <= 1'b0;
         bv_out       <= '0;
         bv_out_cnt   <= '0;
         bv_out_dup   <= 1'b0;
         bv_out_err   <= 1'b0;
      end else if (load) begin
         bv_out_valid <= 1'b1;
         bv_out       <= acc_n;
         bv_out_cnt   <= cnt_n;
         bv_out_dup   <= dup_n;
         bv_out_err   <= err_n;
      end else if (bv_out_valid && bv_out_ready) begin
         bv_out_valid <= 1'b0;
      end
   end

endmodule
